ysyx_22041207_div: RTL

- Iterative restoring divider: one quotient bit per cycle.
- Serves the EX stage's DIV/DIVU/REM/REMU and their word (W) variants; it sits directly beside the ALU, which feeds it operands a/b and consumes its result.
- While it is busy, the ALU holds alu_wait high.
- Results follow RISC-V M-extension semantics, including divide-by-zero and signed overflow.

---
 rtl/ysyx_22041207_div.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22041207_div.sv
// Iterative restoring divider for the EX stage (DIV/DIVU/REM/REMU and W forms).
// Produces one quotient bit per cycle. RISC-V M-extension results, including
// divide-by-zero and signed overflow, come out of the normal datapath.
module ysyx_22041207_div #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            div_signed,
  input  logic            div_word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int WW = 32;
  localparam logic [CNT_W-1:0] LAST_D = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] LAST_W = CNT_W'(WW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;          // partial remainder (magnitude)
  logic [XLEN-1:0]  quo_q, quo_d;          // dividend bits shifting out, quotient bits shifting in
  logic [XLEN-1:0]  dvs_q, dvs_d;          // divisor magnitude
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             word_q, word_d;
  logic [XLEN-1:0]  quotient_q, quotient_d;
  logic [XLEN-1:0]  remainder_q, remainder_d;
  logic             out_valid_q, out_valid_d;

  logic            accept;
  logic            cnt_last;
  logic [XLEN-1:0] a_ext, b_ext;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            b_zero;
  logic [XLEN-1:0] dvd_init, dvs_init, dbz_rem;
  logic [XLEN:0]   shift_rem;
  logic            fits;
  logic [XLEN-1:0] rem_step, quo_step;
  logic [XLEN-1:0] q_fix, r_fix;
  logic [XLEN-1:0] q_out, r_out;

  assign accept   = (state_q == S_IDLE) && div_valid && !flush;
  assign cnt_last = (cnt_q == (word_q ? LAST_W : LAST_D));

  // Operand preparation: width selection, sign capture and magnitude conversion.
  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    a_ext = dividend;
    b_ext = divisor;
    if (div_word) begin
      a_ext = div_signed ? {{(XLEN-WW){dividend[WW-1]}}, dividend[WW-1:0]}
                         : {{(XLEN-WW){1'b0}}, dividend[WW-1:0]};
      b_ext = div_signed ? {{(XLEN-WW){divisor[WW-1]}}, divisor[WW-1:0]}
                         : {{(XLEN-WW){1'b0}}, divisor[WW-1:0]};
    end
    a_neg  = div_signed & a_ext[XLEN-1];
    b_neg  = div_signed & b_ext[XLEN-1];
    // The most-negative value negates to itself, which read unsigned is 2^(N-1).
    a_mag  = a_neg ? -a_ext : a_ext;
    b_mag  = b_neg ? -b_ext : b_ext;
    b_zero = (b_ext == '0);
    // Word dividends are left-aligned so that 32 shifts move every bit into rem.
    dvd_init = div_word ? (a_mag << (XLEN - WW)) : a_mag;
    dvs_init = div_word ? {{(XLEN-WW){1'b0}}, b_mag[WW-1:0]} : b_mag;
    // Divide by zero hands back the dividend, sign-extended from bit 31 for W ops.
    dbz_rem  = div_word ? {{(XLEN-WW){dividend[WW-1]}}, dividend[WW-1:0]} : dividend;
  end

  // One restoring step: shift {rem, quo} left, subtract the divisor when it fits.
  always_comb begin
    shift_rem = {rem_q, quo_q[XLEN-1]};
    fits      = (shift_rem >= {1'b0, dvs_q});
    rem_step  = fits ? (shift_rem[XLEN-1:0] - dvs_q) : shift_rem[XLEN-1:0];
    quo_step  = {quo_q[XLEN-2:0], fits};
  end

  // Sign fix-up of the finished magnitudes, then word-result sign extension.
  always_comb begin
    q_fix = q_neg_q ? -quo_q : quo_q;
    r_fix = r_neg_q ? -rem_q : rem_q;
    q_out = q_fix;
    r_out = r_fix;
    if (word_q) begin
      q_out = {{(XLEN-WW){q_fix[WW-1]}}, q_fix[WW-1:0]};
      r_out = {{(XLEN-WW){r_fix[WW-1]}}, r_fix[WW-1:0]};
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; flush wins over everything and lands in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = b_zero ? S_DONE : S_CALC;
      S_CALC: begin
        if (flush)         state_d = S_IDLE;
        else if (cnt_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state.
  always_comb begin
    div_ready = (state_q == S_IDLE);
  end

  // Datapath next values: latch operands on accept, iterate in CALC, publish in DONE.
  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    word_d      = word_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d  = '0;
          word_d = div_word;
          dvs_d  = dvs_init;
          if (b_zero) begin
            // Preload the final answer; the fix-up stage passes it through untouched.
            quo_d   = '1;
            rem_d   = dbz_rem;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
          end else begin
            quo_d   = dvd_init;
            rem_d   = '0;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
          end
        end
      end
      S_CALC: begin
        if (!flush) begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (!flush) begin
          quotient_d  = q_out;
          remainder_d = r_out;
          out_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  // NOTE: the working registers are reset along with the results; results must read 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      word_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      word_q      <= word_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
